// File: rtl/cp0_commit_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cp0_commit_ctrl_pkg
//   Shared definitions for the commit-stage exception sequencer:
//   - bit positions inside the per-slot 8-bit exception flag vector
//   - MIPS ExcCode constants used when reporting to CP0
//   - sequencer state encoding and BadVAddr source select
//   - default exception vector and the EPC helper
// ---------------------------------------------------------------------------
package cp0_commit_ctrl_pkg;

  // Flag bit positions within slotN_exc
  localparam int FLAG_ADEL_IF = 0;  // address error on instruction fetch
  localparam int FLAG_RI      = 1;  // reserved instruction
  localparam int FLAG_SYS     = 2;  // syscall
  localparam int FLAG_BP      = 3;  // breakpoint
  localparam int FLAG_OV      = 4;  // arithmetic overflow
  localparam int FLAG_ADEL    = 5;  // address error on data load
  localparam int FLAG_ADES    = 6;  // address error on data store
  localparam int FLAG_ERET    = 7;  // exception return

  // ExcCode values written to Cause
  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0A;
  localparam logic [4:0] EXC_OV   = 5'h0C;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_REDIR = 2'd3
  } state_t;

  // Where BadVAddr comes from for the winning event
  typedef enum logic [1:0] {
    BVA_NONE = 2'd0,  // BadVAddr not written
    BVA_PC   = 2'd1,  // fetch address error: faulting PC
    BVA_ADDR = 2'd2   // data address error: load/store address
  } bva_sel_t;

  // EPC points at the branch when the faulting instruction sits in its
  // delay slot, so the branch is re-executed on return.
  function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic is_ds);
    return is_ds ? (pc - 32'd4) : pc;
  endfunction

endpackage

// File: rtl/cp0_commit_ctrl_exc_prio_enc.sv
// ---------------------------------------------------------------------------
// exc_prio_enc
//   Per-slot priority encoder. Reduces the 8 exception flags plus an
//   attached-interrupt bit to a single reportable event.
//   Priority: interrupt > AdEL-fetch > RI > Sys > Bp > Ov > AdEL > AdES > ERET
//
// Ports:
//   flags    in  8  exception flags of the slot (package FLAG_* positions)
//   int_hit  in  1  pending interrupt attached to this slot
//   hit      out 1  slot carries some event
//   exccode  out 5  ExcCode of the winning event (0 for interrupt and ERET)
//   is_eret  out 1  the winning event is ERET
//   bva_sel  out 2  BadVAddr source for the winning event
// ---------------------------------------------------------------------------
module exc_prio_enc
  import cp0_commit_ctrl_pkg::*;
(
  input  logic [7:0] flags,
  input  logic       int_hit,
  output logic       hit,
  output logic [4:0] exccode,
  output logic       is_eret,
  output bva_sel_t   bva_sel
);

  always_comb begin
    hit     = 1'b1;
    exccode = EXC_INT;
    is_eret = 1'b0;
    bva_sel = BVA_NONE;
    if (int_hit) begin
      exccode = EXC_INT;
    end else if (flags[FLAG_ADEL_IF]) begin
      exccode = EXC_ADEL;
      bva_sel = BVA_PC;
    end else if (flags[FLAG_RI]) begin
      exccode = EXC_RI;
    end else if (flags[FLAG_SYS]) begin
      exccode = EXC_SYS;
    end else if (flags[FLAG_BP]) begin
      exccode = EXC_BP;
    end else if (flags[FLAG_OV]) begin
      exccode = EXC_OV;
    end else if (flags[FLAG_ADEL]) begin
      exccode = EXC_ADEL;
      bva_sel = BVA_ADDR;
    end else if (flags[FLAG_ADES]) begin
      exccode = EXC_ADES;
      bva_sel = BVA_ADDR;
    end else if (flags[FLAG_ERET]) begin
      // ERET only survives when nothing else is flagged on the slot
      is_eret = 1'b1;
    end else begin
      hit = 1'b0;
    end
  end

endmodule

// File: rtl/cp0_commit_ctrl.sv
// ---------------------------------------------------------------------------
// cp0_commit_ctrl
//   Commit-stage exception sequencer for the dual-issue pipeline. Picks the
//   oldest excepting slot (attaching a pending interrupt to the oldest valid
//   slot), kills it and the younger work, then runs a registered sequence:
//   CP0 request handshake -> flush for FLUSH_CYCLES -> one redirect pulse.
//
// Handshake: cp0_req_valid rises in REQ and stays high with all cp0_req_*
//   fields frozen until the cycle in which cp0_ready is also high; the
//   request is transferred at that clock edge and valid drops the next cycle.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   slot_valid[1:0]     per-slot commit valid ([0] is the older slot)
//   slot0/1_exc[7:0]    exception flags per slot
//   slot0/1_pc[31:0]    PC per slot
//   slot_is_ds[1:0]     per-slot delay-slot flag
//   slot0/1_badaddr     data address per slot
//   int_pending         interrupt ready to be taken
//   cp0_epc[31:0]       current EPC from CP0 (ERET target)
//   cp0_ready           CP0 accepts the request
//   kill_mask[1:0]      combinational write suppression per slot
//   commit_stall        commit stage held while the sequence runs
//   cp0_req_*           request to CP0 (valid, eret, exccode, epc, bd,
//                       badvaddr_we, badvaddr)
//   flush               flush all stages
//   redirect_valid/pc   one-cycle fetch redirect
//   dbg_state[1:0]      current sequencer state (state_t encoding)
// ---------------------------------------------------------------------------
module cp0_commit_ctrl
  import cp0_commit_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  slot_valid,
  input  logic [7:0]  slot0_exc,
  input  logic [7:0]  slot1_exc,
  input  logic [31:0] slot0_pc,
  input  logic [31:0] slot1_pc,
  input  logic [1:0]  slot_is_ds,
  input  logic [31:0] slot0_badaddr,
  input  logic [31:0] slot1_badaddr,
  input  logic        int_pending,
  input  logic [31:0] cp0_epc,
  input  logic        cp0_ready,
  output logic [1:0]  kill_mask,
  output logic        commit_stall,
  output logic        cp0_req_valid,
  output logic        cp0_req_eret,
  output logic [4:0]  cp0_req_exccode,
  output logic [31:0] cp0_req_epc,
  output logic        cp0_req_bd,
  output logic        cp0_req_badvaddr_we,
  output logic [31:0] cp0_req_badvaddr,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [1:0]  dbg_state
);

  localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES);

  state_t     state;
  logic [3:0] flush_cnt;

  // ---------------- per-slot event decode ----------------
  logic       hit0, hit1;
  logic [4:0] code0, code1;
  logic       eret0, eret1;
  bva_sel_t   sel0, sel1;

  // The interrupt attaches only to the oldest valid slot: slot 1 gets it
  // only when slot 0 is not committing this cycle.
  logic int1;
  assign int1 = int_pending && !slot_valid[0];

  exc_prio_enc u_enc0 (
    .flags   (slot0_exc),
    .int_hit (int_pending),
    .hit     (hit0),
    .exccode (code0),
    .is_eret (eret0),
    .bva_sel (sel0)
  );

  exc_prio_enc u_enc1 (
    .flags   (slot1_exc),
    .int_hit (int1),
    .hit     (hit1),
    .exccode (code1),
    .is_eret (eret1),
    .bva_sel (sel1)
  );

  logic ev0, ev1, ev_any;
  assign ev0    = slot_valid[0] && hit0;
  assign ev1    = slot_valid[1] && hit1;
  assign ev_any = ev0 || ev1;

  // ---------------- winner selection ----------------
  logic [4:0]  w_code;
  logic        w_eret;
  logic [31:0] w_pc;
  logic        w_ds;
  logic [31:0] w_bva;
  logic        w_bva_we;

  always_comb begin
    w_code   = code1;
    w_eret   = eret1;
    w_pc     = slot1_pc;
    w_ds     = slot_is_ds[1];
    w_bva    = 32'h0;
    w_bva_we = 1'b0;
    if (ev0) begin
      w_code = code0;
      w_eret = eret0;
      w_pc   = slot0_pc;
      w_ds   = slot_is_ds[0];
      unique case (sel0)
        BVA_PC:   begin w_bva = slot0_pc;      w_bva_we = 1'b1; end
        BVA_ADDR: begin w_bva = slot0_badaddr; w_bva_we = 1'b1; end
        default:  begin w_bva = 32'h0;         w_bva_we = 1'b0; end
      endcase
    end else begin
      unique case (sel1)
        BVA_PC:   begin w_bva = slot1_pc;      w_bva_we = 1'b1; end
        BVA_ADDR: begin w_bva = slot1_badaddr; w_bva_we = 1'b1; end
        default:  begin w_bva = 32'h0;         w_bva_we = 1'b0; end
      endcase
    end
  end

  // ---------------- kill mask (combinational) ----------------
  // The excepting slot itself is killed (ERET included), plus everything
  // younger. Once the sequence is running, every commit is suppressed.
  always_comb begin
    kill_mask = 2'b00;
    if (rst) begin
      kill_mask = 2'b00;
    end else if (state != ST_IDLE) begin
      kill_mask = 2'b11;
    end else if (ev0) begin
      kill_mask = 2'b11;
    end else if (ev1) begin
      kill_mask = 2'b10;
    end
  end

  // ---------------- sequencer ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= ST_IDLE;
      flush_cnt           <= 4'd0;
      commit_stall        <= 1'b0;
      cp0_req_valid       <= 1'b0;
      cp0_req_eret        <= 1'b0;
      cp0_req_exccode     <= 5'h0;
      cp0_req_epc         <= 32'h0;
      cp0_req_bd          <= 1'b0;
      cp0_req_badvaddr_we <= 1'b0;
      cp0_req_badvaddr    <= 32'h0;
      flush               <= 1'b0;
      redirect_valid      <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (ev_any) begin
            state               <= ST_REQ;
            commit_stall        <= 1'b1;
            cp0_req_valid       <= 1'b1;
            cp0_req_eret        <= w_eret;
            cp0_req_exccode     <= w_code;
            cp0_req_epc         <= epc_of(w_pc, w_ds);
            cp0_req_bd          <= w_ds;
            cp0_req_badvaddr_we <= w_bva_we;
            cp0_req_badvaddr    <= w_bva;
          end
        end
        ST_REQ: begin
          if (cp0_ready) begin
            state         <= ST_FLUSH;
            cp0_req_valid <= 1'b0;
            flush         <= 1'b1;
            flush_cnt     <= CNT_LOAD;
          end
        end
        ST_FLUSH: begin
          flush_cnt <= flush_cnt - 4'd1;
          // A count of 0 is unreachable for legal FLUSH_CYCLES; treating it
          // like 1 keeps the sequence from wrapping the counter.
          if (flush_cnt <= 4'd1) begin
            state          <= ST_REDIR;
            flush          <= 1'b0;
            flush_cnt      <= 4'd0;
            redirect_valid <= 1'b1;
          end
        end
        ST_REDIR: begin
          state          <= ST_IDLE;
          redirect_valid <= 1'b0;
          commit_stall   <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // The ERET target is taken from CP0 during the redirect cycle itself:
  // CP0 has already absorbed the request by then, so its EPC is current.
  assign redirect_pc = !redirect_valid ? 32'h0 :
                       (cp0_req_eret ? cp0_epc : EXC_VECTOR);

  assign dbg_state = state;

endmodule

// File: tb/tb_cp0_commit_ctrl.sv
module tb_cp0_commit_ctrl;

  localparam int          FLUSH_CYCLES = 2;
  localparam logic [31:0] VEC          = 32'hBFC0_0380;
  localparam int          REQ_W        = 72;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  slot_valid;
  logic [7:0]  slot0_exc, slot1_exc;
  logic [31:0] slot0_pc, slot1_pc;
  logic [1:0]  slot_is_ds;
  logic [31:0] slot0_badaddr, slot1_badaddr;
  logic        int_pending;
  logic [31:0] cp0_epc;
  logic        cp0_ready;
  logic [1:0]  kill_mask;
  logic        commit_stall, cp0_req_valid, cp0_req_eret;
  logic [4:0]  cp0_req_exccode;
  logic [31:0] cp0_req_epc;
  logic        cp0_req_bd, cp0_req_badvaddr_we;
  logic [31:0] cp0_req_badvaddr;
  logic        flush, redirect_valid;
  logic [31:0] redirect_pc;
  logic [1:0]  dbg_state;

  cp0_commit_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES), .EXC_VECTOR(VEC)) dut (
    .clk(clk), .rst(rst),
    .slot_valid(slot_valid), .slot0_exc(slot0_exc), .slot1_exc(slot1_exc),
    .slot0_pc(slot0_pc), .slot1_pc(slot1_pc), .slot_is_ds(slot_is_ds),
    .slot0_badaddr(slot0_badaddr), .slot1_badaddr(slot1_badaddr),
    .int_pending(int_pending), .cp0_epc(cp0_epc), .cp0_ready(cp0_ready),
    .kill_mask(kill_mask), .commit_stall(commit_stall),
    .cp0_req_valid(cp0_req_valid), .cp0_req_eret(cp0_req_eret),
    .cp0_req_exccode(cp0_req_exccode), .cp0_req_epc(cp0_req_epc),
    .cp0_req_bd(cp0_req_bd), .cp0_req_badvaddr_we(cp0_req_badvaddr_we),
    .cp0_req_badvaddr(cp0_req_badvaddr), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dbg_state(dbg_state)
  );

  int errors = 0;
  int checks = 0;
  logic [REQ_W-1:0] exp_q[$];

  // ---------------- reference model ----------------
  // One slot: walk the priority table; request packed as
  // {eret, exccode, epc, bd, badvaddr_we, badvaddr}.
  function automatic void slot_model(input logic [7:0] e, input logic irq,
                                     input logic [31:0] pc, input logic ds,
                                     input logic [31:0] ba, output logic hit,
                                     output logic [REQ_W-1:0] r);
    int          codes [7] = '{4, 10, 8, 9, 12, 4, 5};
    logic [31:0] epc;
    logic        bwe;
    logic [31:0] bva;
    epc = ds ? pc - 32'd4 : pc;
    hit = 1'b0;
    r   = '0;
    if (irq) begin
      hit = 1'b1;
      r   = {1'b0, 5'd0, epc, ds, 1'b0, 32'd0};
    end else begin
      for (int i = 0; i < 7; i++) begin
        if (!hit && e[i]) begin
          hit = 1'b1;
          bwe = (i == 0) || (i == 5) || (i == 6);
          bva = (i == 0) ? pc : (bwe ? ba : 32'd0);
          r   = {1'b0, 5'(codes[i]), epc, ds, bwe, bva};
        end
      end
      if (!hit && e[7]) begin
        hit = 1'b1;
        r   = {1'b1, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0};
      end
    end
  endfunction

  function automatic void model(output logic hit, output logic [1:0] kill,
                                output logic [REQ_W-1:0] r);
    logic h0, h1;
    logic [REQ_W-1:0] r0, r1;
    slot_model(slot0_exc, int_pending, slot0_pc, slot_is_ds[0], slot0_badaddr, h0, r0);
    slot_model(slot1_exc, int_pending && !slot_valid[0], slot1_pc, slot_is_ds[1],
               slot1_badaddr, h1, r1);
    h0   = h0 && slot_valid[0];
    h1   = h1 && slot_valid[1];
    hit  = h0 || h1;
    kill = h0 ? 2'b11 : (h1 ? 2'b10 : 2'b00);
    r    = h0 ? r0 : r1;
  endfunction

  // Observed request; EPC/BD are don't-care for ERET.
  function automatic logic [REQ_W-1:0] obs_req();
    return {cp0_req_eret, cp0_req_exccode,
            cp0_req_eret ? 32'd0 : cp0_req_epc, cp0_req_eret ? 1'b0 : cp0_req_bd,
            cp0_req_badvaddr_we, cp0_req_badvaddr};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    slot_valid = 2'b00; slot0_exc = 8'h0; slot1_exc = 8'h0;
    slot0_pc = 32'h0; slot1_pc = 32'h0; slot_is_ds = 2'b00;
    slot0_badaddr = 32'h0; slot1_badaddr = 32'h0; int_pending = 1'b0;
  endtask

  task automatic garble_inputs();
    slot_valid    = 2'($urandom);
    slot0_exc     = 8'($urandom);
    slot1_exc     = 8'($urandom);
    slot0_pc      = $urandom;
    slot1_pc      = $urandom;
    slot_is_ds    = 2'($urandom);
    slot0_badaddr = $urandom;
    slot1_badaddr = $urandom;
    int_pending   = 1'($urandom);
  endtask

  // Inputs carrying an event are already applied; checks the whole
  // sequence from the detection cycle through the return to IDLE.
  task automatic run_event(input string name, input int delay, input int exp_code);
    logic hit;
    logic [1:0] kill;
    logic [REQ_W-1:0] r;
    logic [31:0] exp_pc;
    model(hit, kill, r);
    #1;
    checks++;
    if (kill_mask !== kill) begin
      errors++;
      $display("FAIL %s kill_mask: got %b expected %b", name, kill_mask, kill);
    end
    exp_q.push_back(r);
    exp_pc = r[REQ_W-1] ? cp0_epc : VEC;
    for (int i = 0; i <= delay; i++) begin
      @(negedge clk);
      garble_inputs();
      cp0_ready = (i == delay);
      #1;
      checks++;
      if ({cp0_req_valid, commit_stall, flush, redirect_valid, kill_mask} !== 6'b110011) begin
        errors++;
        $display("FAIL %s req phase %0d: valid/stall/flush/redir/kill got %b expected 110011",
                 name, i, {cp0_req_valid, commit_stall, flush, redirect_valid, kill_mask});
      end
      checks++;
      if (obs_req() !== exp_q[0]) begin
        errors++;
        $display("FAIL %s req fields cycle %0d: got %h expected %h", name, i, obs_req(), exp_q[0]);
      end
      if (i == 0 && exp_code >= 0) begin
        checks++;
        if (cp0_req_exccode !== 5'(exp_code)) begin
          errors++;
          $display("FAIL %s exccode: got %h expected %h", name, cp0_req_exccode, exp_code);
        end
      end
    end
    void'(exp_q.pop_front());
    for (int f = 0; f < FLUSH_CYCLES; f++) begin
      @(negedge clk);
      garble_inputs();
      cp0_ready = 1'($urandom);
      #1;
      checks++;
      if ({cp0_req_valid, commit_stall, flush, redirect_valid, kill_mask} !== 6'b011011) begin
        errors++;
        $display("FAIL %s flush cycle %0d: valid/stall/flush/redir/kill got %b expected 011011",
                 name, f, {cp0_req_valid, commit_stall, flush, redirect_valid, kill_mask});
      end
    end
    @(negedge clk);
    garble_inputs();
    #1;
    checks++;
    if ({cp0_req_valid, commit_stall, flush, redirect_valid} !== 4'b0101 ||
        redirect_pc !== exp_pc) begin
      errors++;
      $display("FAIL %s redirect: valid/stall/flush/redir %b pc %h expected 0101 pc %h",
               name, {cp0_req_valid, commit_stall, flush, redirect_valid}, redirect_pc, exp_pc);
    end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++;
    if ({cp0_req_valid, commit_stall, flush, redirect_valid, dbg_state} !== 6'b000000) begin
      errors++;
      $display("FAIL %s back to idle: valid/stall/flush/redir/state got %b expected 000000",
               name, {cp0_req_valid, commit_stall, flush, redirect_valid, dbg_state});
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    cp0_ready = 1'b1;
    cp0_epc = 32'h0;
    garble_inputs();
    slot_valid = 2'b11;
    slot0_exc = 8'h04;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({kill_mask, commit_stall, cp0_req_valid, cp0_req_eret, cp0_req_exccode, cp0_req_epc,
         cp0_req_bd, cp0_req_badvaddr_we, cp0_req_badvaddr, flush, redirect_valid,
         redirect_pc, dbg_state} !== '0) begin
      errors++;
      $display("FAIL reset outputs: kill %b stall %b valid %b flush %b redir %b state %b expected all 0",
               kill_mask, commit_stall, cp0_req_valid, flush, redirect_valid, dbg_state);
    end
    rst = 1'b0;
    clear_inputs();
    @(negedge clk);
    #1;
    checks++;
    if ({cp0_req_valid, commit_stall, dbg_state} !== 4'b0000) begin
      errors++;
      $display("FAIL reset release idle: got %b expected 0000",
               {cp0_req_valid, commit_stall, dbg_state});
    end
  endtask

  task automatic test_sys();
    clear_inputs();
    slot_valid = 2'b11; slot0_exc = 8'h04; slot0_pc = 32'hBFC0_0100;
    slot1_pc = 32'hBFC0_0104;
    run_event("sys_slot0", 0, 8);
  endtask

  task automatic test_ades_slot1();
    clear_inputs();
    slot_valid = 2'b11; slot1_exc = 8'h40; slot1_badaddr = 32'h8000_0003;
    slot_is_ds = 2'b10; slot1_pc = 32'hBFC0_0208; slot0_pc = 32'hBFC0_0204;
    run_event("ades_slot1_ds", 0, 5);
  endtask

  task automatic test_int_priority();
    clear_inputs();
    int_pending = 1'b1; slot_valid = 2'b01; slot0_exc = 8'h10; slot0_pc = 32'h8000_1000;
    run_event("int_over_ov", 1, 0);
  endtask

  task automatic test_int_wait();
    clear_inputs();
    int_pending = 1'b1;
    slot0_exc = 8'h04;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({kill_mask, cp0_req_valid, commit_stall} !== 4'b0000) begin
        errors++;
        $display("FAIL int_wait cycle %0d: kill/valid/stall got %b expected 0000",
                 i, {kill_mask, cp0_req_valid, commit_stall});
      end
    end
    slot0_exc = 8'h0;
    slot_valid = 2'b10; slot1_pc = 32'h8000_2000;
    run_event("int_on_slot1", 0, 0);
  endtask

  task automatic test_eret();
    clear_inputs();
    cp0_epc = 32'hBFC0_0400;
    slot_valid = 2'b01; slot0_exc = 8'h80; slot0_pc = 32'h8000_3000;
    run_event("eret_ready_late", 3, 0);
    cp0_epc = 32'h0;
  endtask

  task automatic test_reset_mid_flush();
    clear_inputs();
    slot_valid = 2'b01; slot0_exc = 8'h04; slot0_pc = 32'h8000_4000;
    cp0_ready = 1'b1;
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
    #1;
    checks++;
    if (flush !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_flush entry: flush got %b expected 1", flush);
    end
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({cp0_req_valid, commit_stall, flush, redirect_valid, dbg_state} !== 6'b000000) begin
      errors++;
      $display("FAIL rst_mid_flush after reset: valid/stall/flush/redir/state got %b expected 000000",
               {cp0_req_valid, commit_stall, flush, redirect_valid, dbg_state});
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({redirect_valid, flush, cp0_req_valid} !== 3'b000) begin
        errors++;
        $display("FAIL rst_mid_flush quiet cycle %0d: redir/flush/valid got %b expected 000",
                 i, {redirect_valid, flush, cp0_req_valid});
      end
    end
    slot_valid = 2'b01; slot0_exc = 8'h02; slot0_pc = 32'h8000_5000;
    run_event("ri_after_reset", 0, 10);
  endtask

  task automatic test_random();
    logic hit;
    logic [1:0] kill;
    logic [REQ_W-1:0] r;
    for (int n = 0; n < 40; n++) begin
      clear_inputs();
      slot_valid    = 2'($urandom);
      slot0_exc     = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'(1 << $urandom_range(0, 8));
      slot1_exc     = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'(1 << $urandom_range(0, 8));
      slot0_pc      = $urandom & 32'hFFFF_FFFC;
      slot1_pc      = slot0_pc + 32'd4;
      slot_is_ds    = 2'($urandom);
      slot0_badaddr = $urandom;
      slot1_badaddr = $urandom;
      int_pending   = ($urandom_range(0, 3) == 0);
      cp0_epc       = $urandom;
      model(hit, kill, r);
      if (hit) begin
        run_event("random", $urandom_range(0, 3), -1);
      end else begin
        #1;
        checks++;
        if (kill_mask !== 2'b00) begin
          errors++;
          $display("FAIL random idle kill_mask: got %b expected 00", kill_mask);
        end
        @(negedge clk);
        #1;
        checks++;
        if (cp0_req_valid !== 1'b0 || commit_stall !== 1'b0) begin
          errors++;
          $display("FAIL random no event: valid %b stall %b expected 0 0", cp0_req_valid, commit_stall);
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    clear_inputs();
    cp0_ready = 1'b0;
    cp0_epc = 32'h0;
    test_reset();
    test_sys();
    test_ades_slot1();
    test_int_priority();
    test_int_wait();
    test_eret();
    test_reset_mid_flush();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
